// File: rtl/gps_pkg.sv
// Shared GPS C/A types: code-period constants, correlator state/op encodings
// and the signed correction word exchanged with the code generator.
package gps_pkg;

  localparam int unsigned CHIPS_PER_EPOCH = 1023;
  localparam int unsigned CHIP_W          = $clog2(CHIPS_PER_EPOCH);

  typedef enum logic {IDLE, RUN} corr_state_t;

  typedef enum logic [2:0] {
    ACC_HOLD,
    ACC_CLEAR,
    ACC_START,
    ACC_ADD,
    ACC_DUMP
  } accum_op_t;

  typedef logic signed [31:0] code_corr_t;

endpackage

// File: rtl/ca_accum.sv
// One correlation channel: maps a chip onto +/-sample, integrates it, and
// transfers the epoch sum to a held output register on dump.
module ca_accum
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  accum_op_t                  op,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       chip,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] mapped_c;
  logic signed [ACC_W-1:0] next_c;

  // Chip 1 inverts the sample; sign extension happens before negation.
  assign mapped_c = chip ? -ACC_W'(sample) : ACC_W'(sample);
  assign next_c   = sum + mapped_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      acc <= '0;
    end else begin
      case (op)
        ACC_CLEAR: sum <= '0;
        ACC_START: sum <= mapped_c;
        ACC_ADD:   sum <= next_c;
        ACC_DUMP: begin
          acc <= next_c;
          sum <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ca_code_correlator.sv
// E/P/L C/A-code correlator with epoch dump, early-minus-late DLL
// discriminator and punctual-power lock detector.
module ca_code_correlator
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = 8,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned GAIN_SHIFT  = 4,
  parameter int unsigned LOCK_THRESH = 2000,
  parameter int unsigned LOCK_COUNT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       code_e,
  input  logic                       code_p,
  input  logic                       code_l,
  input  logic                       code_epoch,
  output logic                       dump_valid,
  output logic signed [ACC_W-1:0]    acc_e,
  output logic signed [ACC_W-1:0]    acc_p,
  output logic signed [ACC_W-1:0]    acc_l,
  output logic                       corr_valid,
  output code_corr_t                 correction,
  output logic                       lock,
  output logic                       epoch_err
);

  localparam int unsigned HIT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CHIP_W-1:0] LAST_CHIP = CHIP_W'(CHIPS_PER_EPOCH - 1);

  corr_state_t       state;
  logic [CHIP_W-1:0] chip_cnt;
  logic [HIT_W-1:0]  hit_cnt;
  accum_op_t         acc_op_c;

  logic [ACC_W-1:0]        abs_e_c, abs_p_c, abs_l_c;
  logic signed [ACC_W:0]   disc_c;
  logic signed [ACC_W:0]   disc_shift_c;

  // Magnitude with the most-negative code clamped to max positive.
  function automatic logic [ACC_W-1:0] sat_abs(input logic signed [ACC_W-1:0] x);
    if (x == {1'b1, {(ACC_W-1){1'b0}}}) return {1'b0, {(ACC_W-1){1'b1}}};
    else if (x < 0)                      return ACC_W'(-x);
    else                                 return ACC_W'(x);
  endfunction

  always_comb begin
    acc_op_c = ACC_HOLD;
    if (!enable) begin
      acc_op_c = ACC_CLEAR;
    end else if (sample_valid) begin
      case (state)
        IDLE: if (code_epoch) acc_op_c = ACC_START;
        RUN: begin
          if (code_epoch && chip_cnt != '0) acc_op_c = ACC_START;
          else if (chip_cnt == LAST_CHIP)  acc_op_c = ACC_DUMP;
          else                             acc_op_c = ACC_ADD;
        end
        default: acc_op_c = ACC_CLEAR;
      endcase
    end
  end

  ca_accum #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc_e (
    .clk(clk), .rst(rst), .op(acc_op_c), .sample(sample_i), .chip(code_e), .acc(acc_e)
  );
  ca_accum #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc_p (
    .clk(clk), .rst(rst), .op(acc_op_c), .sample(sample_i), .chip(code_p), .acc(acc_p)
  );
  ca_accum #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc_l (
    .clk(clk), .rst(rst), .op(acc_op_c), .sample(sample_i), .chip(code_l), .acc(acc_l)
  );

  // Discriminator operates on the held dump registers.
  assign abs_e_c      = sat_abs(acc_e);
  assign abs_p_c      = sat_abs(acc_p);
  assign abs_l_c      = sat_abs(acc_l);
  assign disc_c       = $signed({1'b0, abs_e_c}) - $signed({1'b0, abs_l_c});
  assign disc_shift_c = disc_c >>> GAIN_SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      chip_cnt   <= '0;
      hit_cnt    <= '0;
      dump_valid <= 1'b0;
      corr_valid <= 1'b0;
      correction <= '0;
      lock       <= 1'b0;
      epoch_err  <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      corr_valid <= 1'b0;
      epoch_err  <= 1'b0;

      case (acc_op_c)
        ACC_CLEAR: begin
          state    <= IDLE;
          chip_cnt <= '0;
        end
        ACC_START: begin
          epoch_err <= (state == RUN);
          state     <= RUN;
          chip_cnt  <= CHIP_W'(1);
        end
        ACC_ADD:  chip_cnt <= chip_cnt + CHIP_W'(1);
        ACC_DUMP: begin
          chip_cnt   <= '0;
          dump_valid <= 1'b1;
        end
        default: ;
      endcase

      // Dump results already registered finish even if enable has dropped.
      if (dump_valid) begin
        corr_valid <= 1'b1;
        correction <= code_corr_t'(disc_shift_c);
        if (abs_p_c >= ACC_W'(LOCK_THRESH)) begin
          if (hit_cnt != HIT_W'(LOCK_COUNT)) hit_cnt <= hit_cnt + HIT_W'(1);
          lock <= (hit_cnt >= HIT_W'(LOCK_COUNT - 1));
        end else begin
          hit_cnt <= '0;
          lock    <= 1'b0;
        end
      end
    end
  end

endmodule
